// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing generator.
// A clock divider produces the pixel enable p_tick; pixel_x/pixel_y walk the
// full raster (visible area plus porches and sync) and never stall.
// Build option VGA_SYNC_OUTREG_EN: video_on/hsync/vsync come from flops loaded
// with the decode of the next-state counters instead of a combinational decode
// of the current counters. Both builds give identical values at clk edges.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit decode bounds so a 1024-wide raster still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEGIN = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] VS_BEGIN = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;

    // {video_on, hsync_n, vsync_n} for a given raster position
    function automatic logic [2:0] decode(input logic [9:0] x, input logic [9:0] y);
        logic [10:0] xe;
        logic [10:0] ye;
        xe = {1'b0, x};
        ye = {1'b0, y};
        decode[2] = (xe < H_VIS) && (ye < V_VIS);
        decode[1] = !((xe >= HS_BEGIN) && (xe < HS_END));
        decode[0] = !((ye >= VS_BEGIN) && (ye < VS_END));
    endfunction

    assign p_tick     = (div_q == DIV_LAST);
    assign frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;

    // Next-state for divider and raster counters; counters move only on p_tick
    always_comb begin
        div_d = p_tick ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Divider and raster counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

`ifdef VGA_SYNC_OUTREG_EN
    logic video_on_q;
    logic hsync_q;
    logic vsync_q;

    // Registered decode of the next position keeps outputs aligned with the counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            video_on_q <= 1'b1;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            {video_on_q, hsync_q, vsync_q} <= decode(x_d, y_d);
        end
    end

    assign video_on = video_on_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
`else
    // Combinational decode of the current position
    always_comb begin
        {video_on, hsync, vsync} = decode(x_q, y_q);
    end
`endif

endmodule
